// File: rtl/gpio_ctrl_pkg.sv
// Shared definitions for the GPIO controller: register offsets, access FSM states, bus width.
package gpio_ctrl_pkg;

    localparam int DATA_W = 32;

    localparam logic [4:0] ADDR_DATA_OUT = 5'h00;
    localparam logic [4:0] ADDR_TRI      = 5'h04;
    localparam logic [4:0] ADDR_DATA_IN  = 5'h08;
    localparam logic [4:0] ADDR_IRQ_EN   = 5'h0C;
    localparam logic [4:0] ADDR_IRQ_STAT = 5'h10;
    localparam logic [4:0] ADDR_EDGE_SEL = 5'h14;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACK      = 2'd1,
        ST_WAIT_LOW = 2'd2
    } acc_state_t;

endpackage

// File: rtl/gpio_ctrl_insync.sv
// Pin input path: 2-flop synchronizer, optional debounce (GPIO_DEBOUNCE_EN), per-pin edge detector.
module gpio_ctrl_insync #(
    parameter int W   = 8,
    parameter int DIV = 1000
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic [W-1:0] pin_raw,
    input  logic [W-1:0] edge_sel,
    output logic [W-1:0] filt,
    output logic [W-1:0] edge_pulse
);

    logic [W-1:0] sync1;
    logic [W-1:0] sync2;
    logic [W-1:0] prev;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pin_raw;
            sync2 <= sync1;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;
    logic          tick;
    logic [W-1:0]  hist0;
    logic [W-1:0]  hist1;
    logic [W-1:0]  deb;
    logic [W-1:0]  stable;

    assign tick   = (cnt == CW'(DIV - 1));
    // A pin is stable when the current sample matches both previous tick samples.
    assign stable = ~(sync2 ^ hist0) & ~(sync2 ^ hist1);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt   <= '0;
            hist0 <= '0;
            hist1 <= '0;
            deb   <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + CW'(1);
            if (tick) begin
                hist1 <= hist0;
                hist0 <= sync2;
                deb   <= (deb & ~stable) | (sync2 & stable);
            end
        end
    end

    assign filt = deb;
`else
    logic unused_div;
    assign unused_div = (DIV > 0);
    assign filt       = sync2;
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            prev <= '0;
        end else begin
            prev <= filt;
        end
    end

    // edge_sel 0 selects rising, 1 selects falling.
    assign edge_pulse = (~edge_sel & filt & ~prev) | (edge_sel & ~filt & prev);

endmodule

// File: rtl/gpio_ctrl.sv
// Register-programmed tri-state GPIO controller with 4-phase register access and edge interrupts.
// Optional input debounce is enabled by defining GPIO_DEBOUNCE_EN.
module gpio_ctrl
    import gpio_ctrl_pkg::*;
#(
    parameter int          C_GPIO_WIDTH   = 8,
    parameter logic [31:0] C_TRI_DEFAULT  = 32'hFFFF_FFFF,
    parameter logic [31:0] C_DOUT_DEFAULT = 32'h0000_0000,
    parameter int          C_DEBOUNCE_DIV = 1000
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    reg_req,
    input  logic                    reg_wr,
    input  logic [4:0]              reg_addr,
    input  logic [DATA_W-1:0]       reg_wdata,
    output logic                    reg_ack,
    output logic [DATA_W-1:0]       reg_rdata,
    output logic [C_GPIO_WIDTH-1:0] m_tri_t,
    output logic [C_GPIO_WIDTH-1:0] m_tri_o,
    input  logic [C_GPIO_WIDTH-1:0] m_tri_i,
    output logic                    irq
);

    localparam int W = C_GPIO_WIDTH;

    acc_state_t        state_q;
    acc_state_t        state_d;
    logic              access;
    logic              wr_en;
    logic              rd_en;
    logic [4:0]        addr_w;
    logic [W-1:0]      wdata_w;

    logic [W-1:0]      data_out;
    logic [W-1:0]      tri_reg;
    logic [W-1:0]      irq_en;
    logic [W-1:0]      irq_stat;
    logic [W-1:0]      edge_sel;
    logic [W-1:0]      data_in;
    logic [W-1:0]      edge_pulse;
    logic [W-1:0]      w1c;
    logic [DATA_W-1:0] rdata_mux;
    logic [DATA_W-1:0] rdata_q;

    logic unused_bits;
    assign unused_bits = &{1'b0, reg_addr[1:0], reg_wdata};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (reg_req) state_d = ST_ACK;
            ST_ACK:      state_d = ST_WAIT_LOW;
            ST_WAIT_LOW: if (!reg_req) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Writes commit and reads capture on the edge that leaves IDLE.
    assign access  = (state_q == ST_IDLE) && reg_req;
    assign wr_en   = access && reg_wr;
    assign rd_en   = access && !reg_wr;
    assign addr_w  = {reg_addr[4:2], 2'b00};
    assign wdata_w = reg_wdata[W-1:0];
    assign reg_ack = (state_q == ST_ACK);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            data_out <= C_DOUT_DEFAULT[W-1:0];
            tri_reg  <= C_TRI_DEFAULT[W-1:0];
            irq_en   <= '0;
            edge_sel <= '0;
        end else if (wr_en) begin
            case (addr_w)
                ADDR_DATA_OUT: data_out <= wdata_w;
                ADDR_TRI:      tri_reg  <= wdata_w;
                ADDR_IRQ_EN:   irq_en   <= wdata_w;
                ADDR_EDGE_SEL: edge_sel <= wdata_w;
                default:       ;
            endcase
        end
    end

    assign w1c = (wr_en && addr_w == ADDR_IRQ_STAT) ? wdata_w : '0;

    // A new edge in the same cycle as its W1C keeps the bit set.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            irq_stat <= '0;
            irq      <= 1'b0;
        end else begin
            irq_stat <= (irq_stat & ~w1c) | edge_pulse;
            irq      <= |(irq_stat & irq_en);
        end
    end

    always_comb begin
        rdata_mux = '0;
        case (addr_w)
            ADDR_DATA_OUT: rdata_mux = DATA_W'(data_out);
            ADDR_TRI:      rdata_mux = DATA_W'(tri_reg);
            ADDR_DATA_IN:  rdata_mux = DATA_W'(data_in);
            ADDR_IRQ_EN:   rdata_mux = DATA_W'(irq_en);
            ADDR_IRQ_STAT: rdata_mux = DATA_W'(irq_stat);
            ADDR_EDGE_SEL: rdata_mux = DATA_W'(edge_sel);
            default:       rdata_mux = '0;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rdata_q <= '0;
        end else if (rd_en) begin
            rdata_q <= rdata_mux;
        end
    end

    assign reg_rdata = rdata_q;
    assign m_tri_t   = tri_reg;
    assign m_tri_o   = data_out;

    gpio_ctrl_insync #(
        .W   (W),
        .DIV (C_DEBOUNCE_DIV)
    ) u_insync (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .pin_raw    (m_tri_i),
        .edge_sel   (edge_sel),
        .filt       (data_in),
        .edge_pulse (edge_pulse)
    );

endmodule
